// File: rtl/ife_block_former_if.sv
// Bundle between the fetch stream, the block former and the downstream block queue.
// master = fetch/queue side, slave = block former.
interface ife_block_former_if #(
  parameter int unsigned BLOCK_ID_WIDTH = 8,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned BLOCK_SIZE     = 4
);
  localparam int unsigned LEN_W = $clog2(BLOCK_SIZE) + 1;

  logic [INSTR_WIDTH-1:0]            instr_in;
  logic                              instr_valid;
  logic                              instr_last;
  logic                              instr_ready;
  logic                              flush;
  logic [BLOCK_ID_WIDTH-1:0]         block_id_out;
  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_out;
  logic [LEN_W-1:0]                  block_len;
  logic                              valid_out;
  logic                              ready_downstream;

  modport master (
    output instr_in, instr_valid, instr_last, flush, ready_downstream,
    input  instr_ready, block_id_out, block_out, block_len, valid_out
  );

  modport slave (
    input  instr_in, instr_valid, instr_last, flush, ready_downstream,
    output instr_ready, block_id_out, block_out, block_len, valid_out
  );
endinterface

// File: rtl/ife_block_former.sv
// Packs fetched instructions into fixed-size, NOP-padded blocks with consecutive IDs.
// Optional idle auto-close of partial blocks: define IFE_BLOCK_FORMER_TIMEOUT_EN.
module ife_block_former #(
  parameter int unsigned            BLOCK_ID_WIDTH = 8,
  parameter int unsigned            INSTR_WIDTH    = 32,
  parameter int unsigned            BLOCK_SIZE     = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = INSTR_WIDTH'(32'h00000013),
  parameter int unsigned            TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  ife_block_former_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BLOCK_SIZE);
  localparam int unsigned LEN_W = IDX_W + 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                            state_r;
  state_t                            state_nxt_s;
  logic [LEN_W-1:0]                  idx_r;
  logic [BLOCK_ID_WIDTH-1:0]         block_id_r;
  logic [INSTR_WIDTH-1:0]            slot_r [BLOCK_SIZE];
  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_s;
  logic                              instr_ready_s;
  logic                              xfer_s;
  logic                              closing_s;
  logic                              handshake_s;
  logic                              flush_clr_s;
  logic                              timeout_s;

  if (BLOCK_SIZE < 2 || (BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0) begin : g_bad_block_size
    $error("ife_block_former: BLOCK_SIZE must be a power of two >= 2");
  end

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ife_block_former: TIMEOUT_CYCLES must be >= 1");
  end

  // Input is refused during reset, while a block is held, and on a flush cycle.
  assign instr_ready_s = !rst && (state_r == FILL) && !bus.flush;
  assign xfer_s        = bus.instr_valid && instr_ready_s;
  assign closing_s     = xfer_s && (bus.instr_last || (idx_r == LEN_W'(BLOCK_SIZE - 1)));
  assign handshake_s   = (state_r == HOLD) && bus.ready_downstream;
  assign flush_clr_s   = (state_r == FILL) && bus.flush;

`ifdef IFE_BLOCK_FORMER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt_r;
  logic            idle_s;

  assign idle_s    = (state_r == FILL) && (idx_r != '0) && !xfer_s && !bus.flush;
  assign timeout_s = idle_s && (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle counter for an open partial block; cleared by any activity or by closing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if (!idle_s || timeout_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + TO_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: close on last/full/timeout, release on downstream accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (closing_s || timeout_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FILL;
        end
      end
      HOLD: begin
        if (bus.ready_downstream) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // Slot/index/ID datapath; a flushed block never consumes an ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r      <= '0;
      block_id_r <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        slot_r[i] <= NOP_INSTR;
      end
    end else if (handshake_s || flush_clr_s) begin
      idx_r <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        slot_r[i] <= NOP_INSTR;
      end
      if (handshake_s) begin
        block_id_r <= block_id_r + BLOCK_ID_WIDTH'(1);
      end
    end else if (xfer_s) begin
      slot_r[idx_r[IDX_W-1:0]] <= bus.instr_in;
      idx_r                    <= idx_r + LEN_W'(1);
    end
  end

  // Pack slots with slot 0 in the least-significant lane.
  always_comb begin
    block_s = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      block_s[i*INSTR_WIDTH +: INSTR_WIDTH] = slot_r[i];
    end
  end

  assign bus.instr_ready  = instr_ready_s;
  assign bus.valid_out    = (state_r == HOLD);
  assign bus.block_out    = block_s;
  assign bus.block_len    = idx_r;
  assign bus.block_id_out = block_id_r;
endmodule

// File: tb/tb_ife_block_former.sv
// Scoreboard bench for ife_block_former: directed stimulus pushes expected blocks,
// a negedge monitor pops and compares on every downstream handshake.
`timescale 1ns/1ps
module tb_ife_block_former;
  localparam int unsigned IDW = 8;
  localparam int unsigned IW  = 32;
  localparam int unsigned BS  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [7:0]   id;
    logic [127:0] data;
    logic [2:0]   len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   handshakes = 0;
  int   h0;
  exp_t exp_q[$];
  exp_t mon_e;

  ife_block_former_if #(.BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS)) bus ();

  ife_block_former #(
    .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS),
    .NOP_INSTR(NOP), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] id, input logic [127:0] data, input logic [2:0] len);
    exp_t e;
    e.id = id; e.data = data; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    bus.instr_in = d; bus.instr_valid = 1'b1; bus.instr_last = last;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bus.instr_ready) ok = 1'b1;
    end
    tick();
    bus.instr_valid = 1'b0; bus.instr_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: instr %h never accepted", d);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.valid_out) seen = 1'b1;
    end
    check(name, 128'(seen), 128'(1));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every downstream handshake must match the oldest expected block.
  always @(negedge clk) begin
    if (!rst && bus.valid_out && bus.ready_downstream) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_block: got id %h len %0d, expected no block", bus.block_id_out, bus.block_len);
      end else begin
        mon_e = exp_q.pop_front();
        check("blk_id", 128'(bus.block_id_out), 128'(mon_e.id));
        check("blk_data", bus.block_out, mon_e.data);
        check("blk_len", 128'(bus.block_len), 128'(mon_e.len));
      end
    end
  end

  initial begin
    bus.instr_in = '0; bus.instr_valid = 1'b0; bus.instr_last = 1'b0;
    bus.flush = 1'b0; bus.ready_downstream = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(bus.instr_ready), 128'(0));
    check("rst_valid", 128'(bus.valid_out), 128'(0));
    check("rst_len", 128'(bus.block_len), 128'(0));
    check("rst_id", 128'(bus.block_id_out), 128'(0));
    check("rst_block", bus.block_out, {4{NOP}});
    tick();
    rst = 1'b0;

    // Full block back-to-back, then single-instruction block closed by last.
    push_exp(8'd0, {32'h44, 32'h33, 32'h22, 32'h11}, 3'd4);
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0);
    check("no_valid_partial", 128'(bus.valid_out), 128'(0));
    send(32'h44, 1'b0);
    @(negedge clk);
    check("latency_valid", 128'(bus.valid_out), 128'(1));
    check("hold_ready", 128'(bus.instr_ready), 128'(0));
    push_exp(8'd1, {NOP, NOP, NOP, 32'hAA}, 3'd1);
    send(32'hAA, 1'b1);
    wait_valid("last_block_valid");

    // Downstream stall for 10 cycles with input and flush offered.
    tick();
    bus.ready_downstream = 1'b0;
    push_exp(8'd2, {32'h104, 32'h103, 32'h102, 32'h101}, 3'd4);
    send(32'h101, 1'b0); send(32'h102, 1'b0); send(32'h103, 1'b0); send(32'h104, 1'b0);
    bus.instr_in = 32'h55; bus.instr_valid = 1'b1; bus.flush = 1'b1;
    h0 = handshakes;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ready", 128'(bus.instr_ready), 128'(0));
      check("stall_valid", 128'(bus.valid_out), 128'(1));
      check("stall_block", bus.block_out, {32'h104, 32'h103, 32'h102, 32'h101});
      check("stall_len", 128'(bus.block_len), 128'(4));
      check("stall_id", 128'(bus.block_id_out), 128'(2));
    end
    tick();
    bus.instr_valid = 1'b0; bus.flush = 1'b0; bus.ready_downstream = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_single_hs", 128'(handshakes - h0), 128'(1));

    // Reset while holding drops the block and restarts IDs at 0.
    tick();
    bus.ready_downstream = 1'b0;
    send(32'h501, 1'b0); send(32'h502, 1'b0); send(32'h503, 1'b0); send(32'h504, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 128'(bus.valid_out), 128'(1));
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("hold_rst_valid", 128'(bus.valid_out), 128'(0));
    check("hold_rst_ready", 128'(bus.instr_ready), 128'(0));
    check("hold_rst_len", 128'(bus.block_len), 128'(0));
    check("hold_rst_block", bus.block_out, {4{NOP}});
    tick();
    rst = 1'b0; bus.ready_downstream = 1'b1;

    // Flush a partial block; the flush-cycle instruction must be refused.
    send(32'h201, 1'b0); send(32'h202, 1'b0);
    bus.flush = 1'b1; bus.instr_in = 32'hDEAD; bus.instr_valid = 1'b1;
    @(negedge clk);
    check("flush_ready", 128'(bus.instr_ready), 128'(0));
    check("pre_flush_len", 128'(bus.block_len), 128'(2));
    tick();
    bus.flush = 1'b0; bus.instr_valid = 1'b0;
    check("post_flush_len", 128'(bus.block_len), 128'(0));
    check("post_flush_block", bus.block_out, {4{NOP}});
    push_exp(8'd0, {32'h304, 32'h303, 32'h302, 32'h301}, 3'd4);
    send(32'h301, 1'b0); send(32'h302, 1'b0); send(32'h303, 1'b0); send(32'h304, 1'b0);
    wait_valid("flush_block_valid");

    // Flush on an empty block is a no-op; ID continues at 1.
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("empty_flush_len", 128'(bus.block_len), 128'(0));
    push_exp(8'd1, {NOP, NOP, 32'h602, 32'h601}, 3'd2);
    send(32'h601, 1'b0); send(32'h602, 1'b1);
    wait_valid("two_block_valid");

    // Idle partial block: auto-close only when the timeout feature is built in.
    tick();
    bus.ready_downstream = 1'b0;
    send(32'h701, 1'b0); send(32'h702, 1'b0); send(32'h703, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("idle15_valid", 128'(bus.valid_out), 128'(0));
    @(negedge clk);
`ifdef IFE_BLOCK_FORMER_TIMEOUT_EN
    check("idle16_valid", 128'(bus.valid_out), 128'(1));
    check("idle16_len", 128'(bus.block_len), 128'(3));
    push_exp(8'd2, {NOP, 32'h703, 32'h702, 32'h701}, 3'd3);
    tick();
    bus.ready_downstream = 1'b1;
`else
    check("idle16_valid", 128'(bus.valid_out), 128'(0));
    check("idle16_len", 128'(bus.block_len), 128'(3));
    push_exp(8'd2, {32'h704, 32'h703, 32'h702, 32'h701}, 3'd4);
    tick();
    bus.ready_downstream = 1'b1;
    send(32'h704, 1'b1);
`endif
    wait_drain();

    // 257 single-instruction blocks from reset: ID wraps 255 -> 0.
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 257; i++) begin
      push_exp(8'(i), {NOP, NOP, NOP, 32'h1000 + 32'(i)}, 3'd1);
      send(32'h1000 + 32'(i), 1'b1);
    end
    wait_drain();
    check("handshake_total", 128'(handshakes), 128'(263));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/ife_block_former.md
IFE_BLOCK_FORMER -- requirements
Module: ife_block_former

Interface
REQ-001 Parameter BLOCK_ID_WIDTH, default 8, width of block sequence ID.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 Parameter BLOCK_SIZE, default 4, instruction slots per block (power of two, >=2).
REQ-004 Parameter NOP_INSTR, default 32'h00000013, pad value for unused slots.
REQ-005 Parameter TIMEOUT_CYCLES, default 16, idle cycles before auto-close (used only with REQ-034).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 instr_in  input  INSTR_WIDTH  incoming instruction.
REQ-009 instr_valid  input  1  instr_in valid.
REQ-010 instr_last  input  1  qualifies instr_in; close block after this instruction.
REQ-011 instr_ready  output  1  former accepts instr_in this cycle.
REQ-012 flush  input  1  discard partially filled block.
REQ-013 block_id_out  output  BLOCK_ID_WIDTH  ID of presented block.
REQ-014 block_out  output  BLOCK_SIZE x INSTR_WIDTH  packed block, slot 0 in least-significant position.
REQ-015 block_len  output  $clog2(BLOCK_SIZE)+1  count of real (non-pad) instructions in block_out.
REQ-016 valid_out  output  1  block presented to the downstream block queue.
REQ-017 ready_downstream  input  1  downstream block queue accepts block (its ready_in).

Function
REQ-018 Two-state FSM: FILL (collecting) and HOLD (presenting complete block).
REQ-019 instr_ready SHALL equal (state==FILL) && !flush; transfer occurs when instr_valid && instr_ready.
REQ-020 On transfer, instr_in SHALL be written to slot[idx] and idx SHALL increment by one.
REQ-021 Transfer into slot BLOCK_SIZE-1, or any transfer with instr_last=1, SHALL move FSM to HOLD on the same edge.
REQ-022 valid_out SHALL be 1 exactly while in HOLD; latency from closing transfer to valid_out=1 is one cycle.
REQ-023 In HOLD, block_out, block_id_out, block_len SHALL be stable until handshake.
REQ-024 Slots not written in the current block SHALL read NOP_INSTR.
REQ-025 block_len SHALL equal number of transfers in the block (1..BLOCK_SIZE).
REQ-026 HOLD with ready_downstream=1: return to FILL, idx=0, all slots reset to NOP_INSTR, block ID +1 modulo 2^BLOCK_ID_WIDTH (wrap to 0).
REQ-027 HOLD with ready_downstream=0: remain in HOLD indefinitely; no input accepted.
REQ-028 flush in FILL: clear idx and slots to NOP_INSTR; block ID SHALL NOT increment; instruction on that cycle not accepted.
REQ-029 flush in HOLD SHALL be ignored; held block is already committed.
REQ-030 flush in FILL with idx=0 SHALL be a no-op.
REQ-031 Block IDs presented on valid_out SHALL be consecutive; no ID consumed by a flushed block.

Reset
REQ-032 While rst=1: state FILL, idx 0, block ID 0, all slots NOP_INSTR, valid_out 0, block_len 0, instr_ready 0 only while rst asserted, timeout counter 0.
REQ-033 rst asserted in HOLD SHALL drop the held block; no handshake occurs that cycle.

Configuration
REQ-034 Macro IFE_BLOCK_FORMER_TIMEOUT_EN defined: in FILL with idx>0, an idle counter increments each cycle without transfer, clears on transfer or flush; on reaching TIMEOUT_CYCLES, FSM SHALL enter HOLD with current partial block (block_len = idx).
REQ-035 Macro undefined: no idle counter; partial block waits in FILL until instr_last, filling, or flush.

Verification
REQ-036 Send 4 instrs 0x11,0x22,0x33,0x44 back-to-back, ready_downstream=1 -> one cycle later valid_out=1, id 0, block_len 4, slots in order; next block id 1.
REQ-037 Send 0xAA with instr_last=1 -> block {0xAA,NOP,NOP,NOP}, block_len 1.
REQ-038 Hold ready_downstream=0 for 10 cycles after full block -> instr_ready=0, outputs stable, no data lost; release -> single handshake.
REQ-039 Send 2 instrs, flush, then 4 instrs -> only one block, id 0, containing the last 4.
REQ-040 Generate 257 blocks -> block_id_out wraps 255 -> 0.
REQ-041 With IFE_BLOCK_FORMER_TIMEOUT_EN, send 3 instrs then idle 16 cycles -> valid_out=1, block_len 3; without macro -> valid_out remains 0.
